// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared constants and types for the LEGv8 fetch stage
package legv8_pkg;
   localparam logic [31:0] NOP_INSTR = 32'h8B1F03FF;
   localparam logic [31:0] HLT_INSTR = 32'hD4400000;

   typedef enum logic [1:0] {FETCH, HALTED, FAULT} fetch_state_t;
   typedef logic [63:0] addr_t;
endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register holding {instr, pc, valid}
module if_id_reg
   import legv8_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        clr,
   input  logic        load,
   input  logic [31:0] new_instr,
   input  addr_t       new_pc,
   output logic [31:0] instr,
   output addr_t       pc,
   output logic        valid
);

   // clr wins over a held (stalled) register so a flush always lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= NOP_INSTR;
         pc    <= '0;
         valid <= 1'b0;
      end else if (clr) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (en && load) begin
         instr <= new_instr;
         pc    <= new_pc;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction fetch: PC, imem handshake, redirect, halt/fault FSM
module fetch_stage
   import legv8_pkg::*;
#(
   parameter addr_t RESET_PC = 64'h0,
   parameter int    IMEM_AW  = 8
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   input  logic               stall_d,
   input  logic               flush_d,
   input  logic               branch_taken,
   input  addr_t              branch_target,
   output logic [31:0]        instr_d,
   output addr_t              pc_d,
   output logic               valid_d,
   output logic               halted,
   output logic               fault
);

   fetch_state_t state, state_next;
   addr_t        pc, pc_next;
   logic         running, xfer, redirect, bubble;

   assign running   = (state == FETCH);
   assign imem_req  = reset & running & ~stall_d & ~branch_taken;
   assign imem_addr = pc[IMEM_AW+1:2];
   assign xfer      = imem_req & imem_ack;
   assign redirect  = running & branch_taken;
   // a redirect cycle also counts as a bubble since no request went out
   assign bubble    = running & ~stall_d & ~xfer;
   assign halted    = (state == HALTED);
   assign fault     = (state == FAULT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      case (state)
         FETCH: begin
            if (branch_taken) begin
               if (branch_target[1:0] != 2'b00) state_next = FAULT;
               else                             pc_next    = branch_target;
            end else if (xfer) begin
               if (imem_rdata == HLT_INSTR) state_next = HALTED;
               else                         pc_next    = pc + 64'd4;
            end
         end
         default: ;
      endcase
   end

   if_id_reg u_if_id (
      .clk       (clk),
      .rst_n     (reset),
      .en        (~stall_d),
      .clr       (flush_d | redirect | bubble),
      .load      (xfer),
      .new_instr (imem_rdata),
      .new_pc    (pc),
      .instr     (instr_d),
      .pc        (pc_d),
      .valid     (valid_d)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and random checks of fetch_stage against a reference model
module tb_fetch_stage;
   import legv8_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall_d = 1'b0;
   logic        flush_d = 1'b0;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_target = '0;
   logic [31:0] instr_d;
   logic [63:0] pc_d;
   logic        valid_d;
   logic        halted;
   logic        fault;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [63:0] m_pc;
   logic [31:0] m_instr;
   logic [63:0] m_pcd;
   bit          m_valid, m_halt, m_fault;

   fetch_stage #(.RESET_PC(64'h0), .IMEM_AW(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .stall_d       (stall_d),
      .flush_d       (flush_d),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_d       (instr_d),
      .pc_d          (pc_d),
      .valid_d       (valid_d),
      .halted        (halted),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_pc    = 64'h0;
      m_instr = NOP_INSTR;
      m_pcd   = 64'h0;
      m_valid = 1'b0;
      m_halt  = 1'b0;
      m_fault = 1'b0;
   endfunction

   function automatic bit model_req(input bit st, input bit br);
      return !m_halt && !m_fault && !st && !br;
   endfunction

   // one rising edge of the fetch stage in plain words
   function automatic void model_edge(input bit st, input bit fl, input bit br,
                                      input logic [63:0] tgt, input bit ack, input logic [31:0] rd);
      bit run;
      bit xf;
      run = !m_halt && !m_fault;
      xf  = model_req(st, br) && ack;
      if (fl || (run && br)) begin
         m_instr = NOP_INSTR;
         m_valid = 1'b0;
      end else if (st) begin
      end else if (xf) begin
         m_instr = rd;
         m_pcd   = m_pc;
         m_valid = 1'b1;
      end else if (run) begin
         m_instr = NOP_INSTR;
         m_valid = 1'b0;
      end
      if (run && br) begin
         if (tgt[1:0] != 2'b00) m_fault = 1'b1;
         else                   m_pc    = tgt;
      end else if (xf) begin
         if (rd == HLT_INSTR) m_halt = 1'b1;
         else                 m_pc   = m_pc + 64'd4;
      end
   endfunction

   task automatic chk_regs();
      chk("instr_d", {32'd0, instr_d}, {32'd0, m_instr});
      chk("pc_d",    pc_d, m_pcd);
      chk("valid_d", {63'd0, valid_d}, {63'd0, m_valid});
      chk("halted",  {63'd0, halted},  {63'd0, m_halt});
      chk("fault",   {63'd0, fault},   {63'd0, m_fault});
   endtask

   task automatic cycle(input bit st, input bit fl, input bit br, input logic [63:0] tgt,
                        input bit ack, input logic [31:0] rd);
      bit er;
      @(negedge clk);
      stall_d = st; flush_d = fl; branch_taken = br; branch_target = tgt;
      imem_ack = ack; imem_rdata = rd;
      #1;
      er = model_req(st, br);
      chk("imem_req", {63'd0, imem_req}, {63'd0, er});
      if (er) chk("imem_addr", {56'd0, imem_addr}, {56'd0, m_pc[9:2]});
      @(posedge clk);
      model_edge(st, fl, br, tgt, ack, rd);
      #1;
      chk_regs();
   endtask

   // asynchronous reset asserted between edges
   task automatic do_reset(input int cycles);
      @(negedge clk);
      #2;
      reset = 1'b0;
      stall_d = 1'b0; flush_d = 1'b0; branch_taken = 1'b0; imem_ack = 1'b1;
      #1;
      model_reset();
      chk_regs();
      chk("req_in_reset", {63'd0, imem_req}, 64'd0);
      repeat (cycles) @(posedge clk);
      #1;
      chk("req_in_reset", {63'd0, imem_req}, 64'd0);
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset(3);

      // back-to-back transfers
      cycle(0, 0, 0, 64'h0, 1, 32'hf8408041);
      chk("t1_instr0", {32'd0, instr_d}, 64'hf8408041);
      chk("t1_pc0", pc_d, 64'h0);
      cycle(0, 0, 0, 64'h0, 1, 32'hf85f8041);
      chk("t1_instr1", {32'd0, instr_d}, 64'hf85f8041);
      chk("t1_pc1", pc_d, 64'h4);
      chk("t1_valid", {63'd0, valid_d}, 64'd1);

      // delayed ack
      cycle(0, 0, 0, 64'h0, 0, 32'hdeadbeef);
      chk("t2_nop", {32'd0, instr_d}, {32'd0, NOP_INSTR});
      cycle(0, 0, 0, 64'h0, 0, 32'hdeadbeef);
      chk("t2_addr_hold", {56'd0, imem_addr}, 64'd2);

      // stall then resume
      cycle(0, 0, 0, 64'h0, 1, 32'h11111111);
      repeat (3) cycle(1, 0, 0, 64'h0, 1, 32'h22222222);
      chk("t3_frozen", pc_d, 64'h8);
      cycle(0, 0, 0, 64'h0, 1, 32'h33333333);
      chk("t3_resume", pc_d, 64'hC);

      // taken branch ignores same-cycle ack
      cycle(0, 0, 1, 64'h40, 1, 32'h44444444);
      chk("t4_valid", {63'd0, valid_d}, 64'd0);
      cycle(0, 0, 0, 64'h0, 1, 32'h55555555);
      chk("t4_pcd", pc_d, 64'h40);

      // misaligned target faults until reset
      cycle(0, 0, 1, 64'h42, 1, 32'h66666666);
      chk("t5_fault", {63'd0, fault}, 64'd1);
      repeat (2) cycle(0, 0, 1, 64'h80, 1, 32'h77777777);
      do_reset(1);
      cycle(0, 0, 0, 64'h0, 0, 32'h0);

      // halt at pc 0xC, then reset out of HALTED
      cycle(0, 0, 0, 64'h0, 1, 32'h8b020020);
      cycle(0, 0, 0, 64'h0, 1, 32'h8b020020);
      cycle(0, 0, 0, 64'h0, 1, 32'h8b020020);
      cycle(0, 0, 0, 64'h0, 1, HLT_INSTR);
      chk("t6_hlt", {32'd0, instr_d}, {32'd0, HLT_INSTR});
      chk("t6_halted", {63'd0, halted}, 64'd1);
      cycle(0, 0, 0, 64'h0, 1, 32'h12345678);
      do_reset(2);
      cycle(0, 0, 0, 64'h0, 1, 32'h8b020020);

      // pc wrap and flush+stall
      cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0);
      cycle(0, 0, 0, 64'h0, 1, 32'haaaa5555);
      chk("t7_pcd", pc_d, 64'hFFFF_FFFF_FFFF_FFFC);
      cycle(0, 0, 0, 64'h0, 0, 32'h0);
      chk("t7_wrap_addr", {56'd0, imem_addr}, 64'd0);
      cycle(1, 1, 0, 64'h0, 1, 32'hbbbbbbbb);
      chk("t7_flush_stall", {63'd0, valid_d}, 64'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit          st, fl, br, ack;
         logic [63:0] tgt;
         logic [31:0] rd;
         st  = ($urandom % 5) == 0;
         fl  = ($urandom % 8) == 0;
         br  = ($urandom % 12) == 0;
         ack = ($urandom % 3) != 0;
         tgt = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
         if (($urandom % 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         rd  = (($urandom % 25) == 0) ? HLT_INSTR : $urandom;
         if ((m_halt || m_fault) && ($urandom % 4) == 0) do_reset(1);
         else cycle(st, fl, br, tgt, ack, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
